// File: rtl/jump_index_encoder_pkg.sv
// Shared constants, error-vector type and helpers for re-encoding J-type jump
// destinations into their 26-bit instruction index.
package jump_index_encoder_pkg;

  localparam int JUMP_IDX_W   = 26;
  localparam int REGION_MSB   = 31;
  localparam int REGION_LSB   = 28;
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_REGION   = 1;

  typedef logic [1:0] jerr_t;

  // The index is simply the word address inside the current 256 MB region.
  function automatic logic [JUMP_IDX_W-1:0] extractIndex(input logic [31:0] target);
    return target[JUMP_IDX_W+1:2];
  endfunction

  function automatic jerr_t calcJumpErr(
    input logic [1:0]                     targetLow,
    input logic [REGION_MSB-REGION_LSB:0] targetRegion,
    input logic [REGION_MSB-REGION_LSB:0] pcRegion
  );
    jerr_t errVec;
    errVec               = 2'b00;
    errVec[ERR_MISALIGN] = (targetLow != 2'b00);
    errVec[ERR_REGION]   = (targetRegion != pcRegion);
    return errVec;
  endfunction

endpackage

// File: rtl/jump_index_check.sv
// Purely combinational alignment and 256 MB region compare feeding stage 1
// of jump_index_encoder.
module jump_index_check
  import jump_index_encoder_pkg::*;
(
  input  logic [31:0]           target,
  input  logic [31:0]           pcPlus4,
  output logic [JUMP_IDX_W-1:0] index,
  output jerr_t                 err
);

  // Only the region nibble of PC+4 matters; the rest is sunk explicitly.
  logic unusedPcBits_s;

  assign unusedPcBits_s = ^pcPlus4[REGION_LSB-1:0];
  assign index          = extractIndex(target);
  assign err            = calcJumpErr(target[1:0],
                                      target[REGION_MSB:REGION_LSB],
                                      pcPlus4[REGION_MSB:REGION_LSB]);

endmodule

// File: rtl/jump_index_encoder.sv
// Two-stage valid/ready pipeline that turns a 32-bit jump target into the
// J-type index and flags misalignment / region mismatch.
// Optional saturating error counter: define JUMP_INDEX_ENC_ERRCNT_EN.
module jump_index_encoder
  import jump_index_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_target,
  input  logic [31:0]           in_pc_plus4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [JUMP_IDX_W-1:0] out_index,
  output logic [1:0]            out_err,
  output logic [CNT_W-1:0]      err_count
);

  logic [JUMP_IDX_W-1:0] chkIndex_s;
  jerr_t                 chkErr_s;

  logic                  s1Valid_r;
  logic [JUMP_IDX_W-1:0] s1Index_r;
  jerr_t                 s1Err_r;
  logic                  s2Valid_r;
  logic [JUMP_IDX_W-1:0] s2Index_r;
  jerr_t                 s2Err_r;

  logic                  s1Advance_s;
  logic                  inAccept_s;
  logic                  outXfer_s;
  logic                  inReady_s;

  jump_index_check uCheck (
    .target  (in_target),
    .pcPlus4 (in_pc_plus4),
    .index   (chkIndex_s),
    .err     (chkErr_s)
  );

  // Handshake decode; in_ready deliberately depends on out_ready (no skid buffer).
  always_comb begin
    s1Advance_s = 1'b0;
    inReady_s   = 1'b0;
    inAccept_s  = 1'b0;
    outXfer_s   = 1'b0;
    if (s1Valid_r && (!s2Valid_r || out_ready)) begin
      s1Advance_s = 1'b1;
    end else begin
      s1Advance_s = 1'b0;
    end
    inReady_s  = !s1Valid_r || s1Advance_s;
    inAccept_s = in_valid && inReady_s;
    outXfer_s  = s2Valid_r && out_ready;
  end

  // Stage valids; flush wins over any accept or advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_r <= 1'b0;
      s2Valid_r <= 1'b0;
    end else if (flush) begin
      s1Valid_r <= 1'b0;
      s2Valid_r <= 1'b0;
    end else begin
      if (inAccept_s) begin
        s1Valid_r <= 1'b1;
      end else if (s1Advance_s) begin
        s1Valid_r <= 1'b0;
      end else begin
        s1Valid_r <= s1Valid_r;
      end
      if (s1Advance_s) begin
        s2Valid_r <= 1'b1;
      end else if (outXfer_s) begin
        s2Valid_r <= 1'b0;
      end else begin
        s2Valid_r <= s2Valid_r;
      end
    end
  end

  // Stage payloads; S2 only changes when S1 advances, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Index_r <= {JUMP_IDX_W{1'b0}};
      s1Err_r   <= 2'b00;
      s2Index_r <= {JUMP_IDX_W{1'b0}};
      s2Err_r   <= 2'b00;
    end else begin
      if (inAccept_s) begin
        s1Index_r <= chkIndex_s;
        s1Err_r   <= chkErr_s;
      end
      if (s1Advance_s) begin
        s2Index_r <= s1Index_r;
        s2Err_r   <= s1Err_r;
      end
    end
  end

  assign in_ready  = inReady_s;
  assign out_valid = s2Valid_r;
  assign out_index = s2Index_r;
  assign out_err   = s2Err_r;

`ifdef JUMP_INDEX_ENC_ERRCNT_EN
  logic [CNT_W-1:0] errCnt_r;

  // Saturating count of issued results carrying any error; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt_r <= {CNT_W{1'b0}};
    end else if (outXfer_s && (s2Err_r != 2'b00) && (errCnt_r != {CNT_W{1'b1}})) begin
      errCnt_r <= errCnt_r + CNT_W'(1);
    end else begin
      errCnt_r <= errCnt_r;
    end
  end

  assign err_count = errCnt_r;
`else
  assign err_count = {CNT_W{1'b0}};
`endif

endmodule
